// File: rtl/ps2_pkg.sv
// ----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 host-side blocks (transmitter, receiver,
// keyboard glue).
//   - ps2_state_t : host transmitter state encoding
//   - CMD_* / RSP_* : PS/2 keyboard command and response bytes
//   - odd_parity() : parity bit that makes the 9-bit data+parity word odd
// ----------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        SEND,
        ACK,
        WAIT_IDLE,
        ERR
    } ps2_state_t;

    localparam logic [7:0] CMD_SET_LEDS  = 8'hED;
    localparam logic [7:0] CMD_RESET     = 8'hFF;
    localparam logic [7:0] CMD_TYPEMATIC = 8'hF3;
    localparam logic [7:0] RSP_ACK       = 8'hFA;
    localparam logic [7:0] RSP_RESEND    = 8'hFE;

    // Odd parity: 1 when the byte holds an even number of ones.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_sync.sv
// ----------------------------------------------------------------------------
// ps2_sync
// Two-flop synchronizer for a raw PS/2 pad input, followed by a registered
// previous-value stage used for falling-edge detection.
// Ports:
//   clk    in  system clock
//   reset  in  synchronous reset, active-high
//   pad_in in  asynchronous pad input
//   sync   out synchronized pad level
//   fe     out high for one cycle when sync goes 1 -> 0
// ----------------------------------------------------------------------------
module ps2_sync (
    input  logic clk,
    input  logic reset,
    input  logic pad_in,
    output logic sync,
    output logic fe
);

    logic meta_reg;
    logic sync_reg;
    logic prev_reg;

    // Reset to 1 (idle bus level) so leaving reset never fakes an edge on a
    // line that is already high.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_reg <= 1'b1;
            sync_reg <= 1'b1;
            prev_reg <= 1'b1;
        end else begin
            meta_reg <= pad_in;
            sync_reg <= meta_reg;
            prev_reg <= sync_reg;
        end
    end

    assign sync = sync_reg;
    assign fe   = prev_reg & ~sync_reg;

endmodule

// File: rtl/ps2_host_tx.sv
// ----------------------------------------------------------------------------
// ps2_host_tx
// PS/2 host-to-device transmitter. Inhibits the bus, places the start bit,
// releases the clock and then shifts out 8 data bits (LSB first), odd parity
// and the stop bit on the device-generated falling clock edges, finally
// checking the device ACK on the 11th falling edge.
//
// Optional feature macro: PS2_TX_TIMEOUT_EN
//   defined   : watchdog aborts to ERR if the device never clocks
//               (TIMEOUT_CYCLES after clock release) or the frame does not
//               finish within FRAME_CYCLES of the first falling edge.
//   undefined : no watchdog; a silent device holds the block busy until reset.
//
// Ports:
//   clk        in  system clock
//   reset      in  synchronous reset, active-high
//   tx_data    in  command byte, captured when tx_valid && tx_ready
//   tx_valid   in  send request
//   tx_ready   out high only while idle
//   tx_done    out one-cycle pulse: frame sent and ACK seen
//   tx_error   out one-cycle pulse: missing ACK or watchdog expiry
//   busy       out high whenever not idle (receiver rx_inhibit)
//   ps2_clk_in in  raw PS/2 clock pad
//   ps2_dat_in in  raw PS/2 data pad
//   ps2_clk_oe out 1 = pull clock pad low
//   ps2_dat_oe out 1 = pull data pad low
// ----------------------------------------------------------------------------
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int START_CYCLES   = 100,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FRAME_CYCLES   = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam logic [19:0] INHIBIT_LAST = 20'(INHIBIT_CYCLES - 1);
    localparam logic [19:0] START_LAST   = 20'(START_CYCLES - 1);
    localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CYCLES - 1);
    localparam logic [19:0] FRAME_LAST   = 20'(FRAME_CYCLES - 1);

    logic clk_sync;
    logic clk_fe;
    logic dat_sync;
    logic dat_fe_unused;

    ps2_sync u_clk_sync (
        .clk    (clk),
        .reset  (reset),
        .pad_in (ps2_clk_in),
        .sync   (clk_sync),
        .fe     (clk_fe)
    );

    ps2_sync u_dat_sync (
        .clk    (clk),
        .reset  (reset),
        .pad_in (ps2_dat_in),
        .sync   (dat_sync),
        .fe     (dat_fe_unused)
    );

    ps2_state_t  state_reg;
    logic [19:0] cnt_reg;
    logic [3:0]  fe_cnt_reg;
    logic [7:0]  shift_reg;
    logic        parity_reg;
    logic        clk_oe_reg;
    logic        dat_oe_reg;
    logic        ready_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        error_reg;

    // Before the first falling edge the counter measures time since clock
    // release; from the first edge on it measures frame duration.
    logic wd_hit;
    assign wd_hit = (fe_cnt_reg == 4'd0) ? (cnt_reg == TIMEOUT_LAST)
                                         : (cnt_reg == FRAME_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            fe_cnt_reg <= '0;
            shift_reg  <= '0;
            parity_reg <= 1'b0;
            clk_oe_reg <= 1'b0;
            dat_oe_reg <= 1'b0;
            ready_reg  <= 1'b1;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            error_reg  <= 1'b0;
        end else begin
            done_reg  <= 1'b0;
            error_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    clk_oe_reg <= 1'b0;
                    dat_oe_reg <= 1'b0;
                    ready_reg  <= 1'b1;
                    // Gate on ready_reg so the cycle carrying tx_done/tx_error
                    // cannot accept a new byte.
                    if (tx_valid && ready_reg) begin
                        shift_reg  <= tx_data;
                        parity_reg <= odd_parity(tx_data);
                        cnt_reg    <= '0;
                        clk_oe_reg <= 1'b1;
                        busy_reg   <= 1'b1;
                        ready_reg  <= 1'b0;
                        state_reg  <= INHIBIT;
                    end
                end

                INHIBIT: begin
                    if (cnt_reg == INHIBIT_LAST) begin
                        cnt_reg    <= '0;
                        dat_oe_reg <= 1'b1;
                        state_reg  <= START;
                    end else begin
                        cnt_reg <= cnt_reg + 20'd1;
                    end
                end

                START: begin
                    if (cnt_reg == START_LAST) begin
                        cnt_reg    <= '0;
                        fe_cnt_reg <= '0;
                        clk_oe_reg <= 1'b0;   // start bit stays driven
                        state_reg  <= SEND;
                    end else begin
                        cnt_reg <= cnt_reg + 20'd1;
                    end
                end

                SEND: begin
                    if (clk_fe) begin
                        fe_cnt_reg <= fe_cnt_reg + 4'd1;
                        if (fe_cnt_reg == 4'd0) begin
                            cnt_reg <= '0;
                        end else if (!wd_hit) begin
                            cnt_reg <= cnt_reg + 20'd1;
                        end
                        if (fe_cnt_reg < 4'd8) begin
                            dat_oe_reg <= ~shift_reg[0];
                            shift_reg  <= {1'b0, shift_reg[7:1]};
                        end else if (fe_cnt_reg == 4'd8) begin
                            dat_oe_reg <= ~parity_reg;
                        end else begin
                            dat_oe_reg <= 1'b0;   // stop bit: line released
                            state_reg  <= ACK;
                        end
                    end else begin
`ifdef PS2_TX_TIMEOUT_EN
                        if (wd_hit) begin
                            clk_oe_reg <= 1'b0;
                            dat_oe_reg <= 1'b0;
                            state_reg  <= ERR;
                        end else begin
                            cnt_reg <= cnt_reg + 20'd1;
                        end
`else
                        if (!wd_hit) begin
                            cnt_reg <= cnt_reg + 20'd1;
                        end
`endif
                    end
                end

                ACK: begin
                    if (clk_fe) begin
                        fe_cnt_reg <= fe_cnt_reg + 4'd1;
                        if (!dat_sync) begin
                            state_reg <= WAIT_IDLE;
                        end else begin
                            clk_oe_reg <= 1'b0;
                            dat_oe_reg <= 1'b0;
                            state_reg  <= ERR;
                        end
                    end else begin
`ifdef PS2_TX_TIMEOUT_EN
                        if (wd_hit) begin
                            clk_oe_reg <= 1'b0;
                            dat_oe_reg <= 1'b0;
                            state_reg  <= ERR;
                        end else begin
                            cnt_reg <= cnt_reg + 20'd1;
                        end
`else
                        if (!wd_hit) begin
                            cnt_reg <= cnt_reg + 20'd1;
                        end
`endif
                    end
                end

                WAIT_IDLE: begin
                    // Device releases data after its ACK clock; finish only
                    // once the bus is fully idle again.
                    if (clk_sync && dat_sync) begin
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end

                ERR: begin
                    clk_oe_reg <= 1'b0;
                    dat_oe_reg <= 1'b0;
                    error_reg  <= 1'b1;
                    busy_reg   <= 1'b0;
                    state_reg  <= IDLE;
                end

                default: begin
                    clk_oe_reg <= 1'b0;
                    dat_oe_reg <= 1'b0;
                    busy_reg   <= 1'b0;
                    state_reg  <= IDLE;
                end
            endcase
        end
    end

    assign tx_ready   = ready_reg;
    assign tx_done    = done_reg;
    assign tx_error   = error_reg;
    assign busy       = busy_reg;
    assign ps2_clk_oe = clk_oe_reg;
    assign ps2_dat_oe = dat_oe_reg;

endmodule
